fir_coeff_loader: RTL
=====================

Name: fir_coeff_loader

Overview:
- Upstream configuration stage for the transposed FIR chain. It receives NUM_TAPS coefficients serially over a valid/ready stream and collects them in a shadow bank.
- It then commits the shadow bank atomically to the active bank on a sample boundary. Each tap's iv_weight is driven from the active bank.
- A coefficient set therefore never changes partway through a sample, and the chain keeps filtering with the old set while a new set loads.

Parameters:
- DATA_WIDTH, 24, coefficient width, signed two's complement; matches tap DATA_WIDTH.
- NUM_TAPS, 16, number of taps/coefficients; must be >= 2.
- CNT_WIDTH, $clog2(NUM_TAPS), width of the load index counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load_start  in  1  single-cycle request to begin loading a new coefficient set.
- iv_coeff  in  DATA_WIDTH  signed coefficient data.
- i_coeff_valid  in  1  iv_coeff valid.
- o_coeff_ready  out  1  loader accepts iv_coeff this cycle.
- i_sample_en  in  1  the same enable strobe that clocks the taps (i_en); marks the sample boundary.
- ov_weights  out  NUM_TAPS*DATA_WIDTH  active bank, flattened; tap k uses ov_weights[k*DATA_WIDTH +: DATA_WIDTH].
- o_busy  out  1  high while state != IDLE.
- o_swap  out  1  one-cycle pulse in the cycle after the active bank is updated.
- o_restart  out  1  one-cycle pulse in the cycle after an in-progress load is restarted.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State=IDLE, index=0.
  - Shadow and active banks all zero, so ov_weights=0.
  - o_coeff_ready, o_busy, o_swap and o_restart all 0.
  - Reset mid-load discards the partial set; the active bank returns to zero.
- State IDLE:
  - o_coeff_ready=0.
  - i_load_start=1 -> LOAD, index<=0.
- State LOAD:
  - o_coeff_ready=1, decoded from the registered state with no combinational path from i_coeff_valid.
  - A transfer occurs when valid&ready at a rising edge; then shadow[index]<=iv_coeff.
  - If index==NUM_TAPS-1 -> PENDING, index<=0; otherwise index<=index+1.
  - Order: the first accepted word goes to tap 0, the last to tap NUM_TAPS-1.
  - valid=0 stalls indefinitely, with no timeout.
- State PENDING:
  - o_coeff_ready=0.
  - At the first edge where i_sample_en=1: active<=shadow (all taps in the same edge), then -> IDLE, and o_swap=1 in the following cycle.
  - Taps registering at that same edge still see the old weights. The new set applies from the next enabled sample onward.
- Final transfer coinciding with i_sample_en=1: no swap in that cycle. The swap waits for the next i_sample_en, because PENDING is entered only after that edge.
- i_load_start while in LOAD or PENDING (restart):
  - -> LOAD, index<=0, o_restart=1 next cycle.
  - Any transfer in the same cycle is dropped.
  - The pending swap is cancelled; the active bank is untouched.
  - Shadow entries are overwritten as the new transfers arrive.
- i_load_start while in IDLE: handled as normal start only, with no o_restart.
- i_load_start in the same cycle as a PENDING swap edge (i_sample_en=1): restart wins, and no swap occurs.
- Width rules:
  - Coefficients are stored bit-exact, with no scaling or saturation.
  - ov_weights is driven straight from registers, with no combinational logic between the active bank and the output.
- Throughput: one coefficient per cycle. A full load takes NUM_TAPS cycles plus the wait for the next i_sample_en.

Test Plan:
- Reset: hold i_rst_n=0 asynchronously mid-cycle -> ov_weights=0, o_busy=0, o_coeff_ready=0 immediately, without waiting for a clock edge.
- Basic load (NUM_TAPS=4): pulse start, stream 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFE with valid held high, i_sample_en=0:
  - ov_weights stays 0 throughout.
  - Raise i_sample_en -> after that edge, taps 0..3 = 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFE.
  - o_swap pulses once; o_busy falls.
- Backpressure/gaps: toggle valid 1,0,0,1,... across the 4 words -> exactly 4 transfers, order preserved, and o_coeff_ready stays high until the 4th transfer.
- Boundary coincidence: assert i_sample_en on the cycle of the 4th transfer -> no swap that edge; swap on the next i_sample_en.
- Restart: after 2 words, pulse i_load_start, then load 4 new words (0x10, 0x20, 0x30, 0x40) -> o_restart pulses once; the old active set is held until swap; after swap the weights are 0x10..0x40.
- Integration: connect to a 4-tap transposed chain, preload h={0x400000, 0, 0, 0}, feed an impulse, reload h={0, 0x400000, 0, 0} mid-stream -> no output sample shows a mixed coefficient set.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader for the transposed FIR chain.
// Fills a shadow bank, then commits it to the active bank on a sample boundary.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_TAPS   = 16,
    parameter int CNT_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_load_start,
    input  logic signed [DATA_WIDTH-1:0]   iv_coeff,
    input  logic                           i_coeff_valid,
    output logic                           o_coeff_ready,
    input  logic                           i_sample_en,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
    output logic                           o_busy,
    output logic                           o_swap,
    output logic                           o_restart
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_TAPS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   index;
    logic [CNT_WIDTH-1:0]   index_nxt;
    logic                   xfer;
    logic                   swap;
    logic                   restart;
    logic [DATA_WIDTH-1:0]  shadow [NUM_TAPS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            index     <= '0;
            o_swap    <= 1'b0;
            o_restart <= 1'b0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            o_swap    <= swap;
            o_restart <= restart;
        end
    end

    // A start request outranks both a same-cycle transfer and a swap.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        xfer      = 1'b0;
        swap      = 1'b0;
        restart   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_load_start) begin
                    state_nxt = LOAD;
                    index_nxt = '0;
                end
            end
            LOAD: begin
                if (i_load_start) begin
                    restart   = 1'b1;
                    index_nxt = '0;
                end else if (i_coeff_valid) begin
                    xfer = 1'b1;
                    if (index == LAST) begin
                        state_nxt = PENDING;
                        index_nxt = '0;
                    end else begin
                        index_nxt = index + CNT_WIDTH'(1);
                    end
                end
            end
            PENDING: begin
                if (i_load_start) begin
                    restart   = 1'b1;
                    state_nxt = LOAD;
                    index_nxt = '0;
                end else if (i_sample_en) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                index_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
            end
            ov_weights <= '0;
        end else begin
            if (xfer) begin
                shadow[index] <= iv_coeff;
            end
            if (swap) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    ov_weights[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
                end
            end
        end
    end

    assign o_coeff_ready = (state == LOAD);
    assign o_busy        = (state != IDLE);

endmodule
